pe_array_sequencer: RTL

Sequencer for a linear chain of N multiply-accumulate processing elements (PEs). It loads weights by shifting them through the chain's data path and committing them with a one-cycle write-enable. It then streams input samples, drains the pipeline with zeros, and returns one accumulated result per input sample with valid/ready backpressure. It sits between the weight/sample stream sources and the PE array, and is the only block that drives the array's data, write-enable and advance-enable.

---
 rtl/pe_array_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: drives a linear MAC PE chain through weight load,
// commit, sample streaming and drain, returning one sum per sample.
module pe_array_sequencer #(
    parameter int N        = 8,
    parameter int W        = 18,
    parameter int LEN_W    = 16,
    parameter int PIPE_LAT = N + 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cfg_start,
    input  logic             cfg_reload,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    output logic             done,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [W-1:0]     w_data,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [W-1:0]     x_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [W-1:0]     y_data,
    output logic             y_last,
    output logic [W-1:0]     pe_din,
    output logic             pe_we,
    output logic             pe_en,
    input  logic [W-1:0]     pe_sumo
);
    localparam int WCW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_nstate;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_xcnt;
    logic [LEN_W-1:0]    r_ocnt;
    logic [WCW-1:0]      r_wcnt;
    logic [PIPE_LAT-1:0] r_tag;

    logic             w_tail;
    logic             w_adv;
    logic             w_shift;
    logic [LEN_W-1:0] w_len_m1;

    assign w_tail   = r_tag[PIPE_LAT-1];
    assign w_len_m1 = r_len - LEN_W'(1);
    assign y_data   = pe_sumo;
    assign y_last   = y_valid && (r_ocnt == w_len_m1);
    assign w_shift  = pe_en &&
                      (r_state == S_STREAM || r_state == S_DRAIN);

    always_comb begin
        w_nstate = r_state;
        w_adv    = 1'b0;
        pe_en    = 1'b0;
        pe_we    = 1'b0;
        pe_din   = '0;
        w_ready  = 1'b0;
        x_ready  = 1'b0;
        y_valid  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    if (cfg_reload)
                        w_nstate = S_LOAD;
                    else if (cfg_len != '0)
                        w_nstate = S_STREAM;
                    else
                        w_nstate = S_DONE;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                w_ready = 1'b1;
                pe_din  = w_data;
                w_adv   = w_valid;
                pe_en   = w_adv && (!w_tail || y_ready);
                if (w_valid && r_wcnt == WCW'(N - 1))
                    w_nstate = S_COMMIT;
            end
            S_COMMIT: begin
                busy     = 1'b1;
                pe_we    = 1'b1;
                pe_en    = 1'b1;
                w_nstate = (r_len != '0) ? S_STREAM : S_DONE;
            end
            S_STREAM: begin
                busy    = 1'b1;
                pe_din  = x_data;
                w_adv   = x_valid;
                pe_en   = w_adv && (!w_tail || y_ready);
                x_ready = pe_en;
                y_valid = w_tail && w_adv;
                if (pe_en && r_xcnt == w_len_m1)
                    w_nstate = S_DRAIN;
            end
            S_DRAIN: begin
                busy    = 1'b1;
                w_adv   = 1'b1;
                pe_en   = !w_tail || y_ready;
                y_valid = w_tail;
                if (y_valid && y_ready && r_ocnt == w_len_m1)
                    w_nstate = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                w_nstate = S_IDLE;
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_xcnt  <= '0;
            r_ocnt  <= '0;
            r_wcnt  <= '0;
            r_tag   <= '0;
        end else begin
            r_state <= w_nstate;
            if (r_state == S_IDLE && cfg_start) begin
                r_len  <= cfg_len;
                r_xcnt <= '0;
                r_ocnt <= '0;
                r_wcnt <= '0;
            end
            if (r_state == S_LOAD && w_valid)
                r_wcnt <= r_wcnt + WCW'(1);
            if (x_ready && x_valid)
                r_xcnt <= r_xcnt + LEN_W'(1);
            if (y_valid && y_ready)
                r_ocnt <= r_ocnt + LEN_W'(1);
            // a 1 marks a real sample; drain advances push bubbles
            if (w_shift)
                r_tag <= {r_tag[PIPE_LAT-2:0], (r_state == S_STREAM)};
        end
    end
endmodule
